// File: rtl/mig_icb_pkg.sv
// Shared types and constants for the MIG ICB responder.
// Supplies default bus widths when the SoC header has not defined them.
`ifndef MYRISCV_ADDRDW
`define MYRISCV_ADDRDW 32
`endif
`ifndef MYRISCV_DATADW
`define MYRISCV_DATADW 32
`endif

package mig_icb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_CMD,
        RD_WAIT,
        RSP
    } state_e;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    localparam int LANE_W = 2;

endpackage

// File: rtl/mig_icb_rd_timeout.sv
// Read-wait watchdog: counts cycles spent waiting on a read and pulses expire_o
// on the last allowed cycle. Only built when MIG_ICB_RD_TIMEOUT_EN is defined.
module mig_icb_rd_timeout #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic active_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = active_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (active_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mig_icb_responder.sv
// ICB responder bridging single-beat 32-bit ICB commands onto a DDR controller app_* port.
// Optional read watchdog enabled by defining MIG_ICB_RD_TIMEOUT_EN.
module mig_icb_responder
    import mig_icb_pkg::*;
#(
    parameter int APP_AW      = 28,
    parameter int APP_DW      = 128,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mig_icb_cmd_valid_i,
    output logic                       mig_icb_cmd_ready_o,
    input  logic [`MYRISCV_ADDRDW-1:0] mig_icb_cmd_addr_i,
    input  logic                       mig_icb_cmd_read_i,
    input  logic [31:0]                mig_icb_cmd_wdata_i,
    input  logic [3:0]                 mig_icb_cmd_wmask_i,
    input  logic [1:0]                 mig_icb_cmd_burst_i,
    input  logic [1:0]                 mig_icb_cmd_beat_i,
    input  logic [1:0]                 mig_icb_cmd_size_i,
    input  logic                       mig_icb_cmd_lock_i,
    input  logic                       mig_icb_cmd_excl_i,
    output logic                       mig_icb_rsp_valid_o,
    input  logic                       mig_icb_rsp_ready_i,
    output logic                       mig_icb_rsp_err_o,
    output logic                       mig_icb_rsp_excl_ok_o,
    output logic [31:0]                mig_icb_rsp_rdata_o,
    input  logic                       init_calib_complete_i,
    output logic                       app_en_o,
    output logic [2:0]                 app_cmd_o,
    output logic [APP_AW-1:0]          app_addr_o,
    input  logic                       app_rdy_i,
    output logic                       app_wdf_wren_o,
    output logic                       app_wdf_end_o,
    output logic [APP_DW-1:0]          app_wdf_data_o,
    output logic [APP_DW/8-1:0]        app_wdf_mask_o,
    input  logic                       app_wdf_rdy_i,
    input  logic [APP_DW-1:0]          app_rd_data_i,
    input  logic                       app_rd_data_valid_i
);

    state_e state_q, state_d;

    logic [APP_AW-4:0] addr_q;
    logic [LANE_W-1:0] lane_q;
    logic              read_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;

    logic        en_q, en_d;
    logic        wren_q, wren_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic cmd_fire;
    logic wr_both_done;
    logic rd_timeout;
    logic unused_inputs;

    assign mig_icb_cmd_ready_o = (state_q == IDLE) && init_calib_complete_i;
    assign cmd_fire            = mig_icb_cmd_valid_i && mig_icb_cmd_ready_o;
    assign wr_both_done        = (!en_q || app_rdy_i) && (!wren_q || app_wdf_rdy_i);

`ifdef MIG_ICB_RD_TIMEOUT_EN
    mig_icb_rd_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rd_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cmd_fire && mig_icb_cmd_read_i),
        .active_i((state_q == RD_CMD) || (state_q == RD_WAIT)),
        .expire_o(rd_timeout)
    );
`else
    assign rd_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            lane_q      <= '0;
            read_q      <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            en_q        <= 1'b0;
            wren_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            wren_q      <= wren_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            if (cmd_fire) begin
                addr_q  <= mig_icb_cmd_addr_i[APP_AW:4];
                lane_q  <= mig_icb_cmd_addr_i[3:2];
                read_q  <= mig_icb_cmd_read_i;
                wdata_q <= mig_icb_cmd_wdata_i;
                wmask_q <= mig_icb_cmd_wmask_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_fire) state_d = mig_icb_cmd_read_i ? RD_CMD : WR;
            WR:      if (wr_both_done) state_d = RSP;
            RD_CMD:  if (rd_timeout) state_d = RSP;
                     else if (app_rdy_i) state_d = RD_WAIT;
            RD_WAIT: if (rd_timeout || app_rd_data_valid_i) state_d = RSP;
            RSP:     if (mig_icb_rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; the timeout wins over a same-cycle handshake.
    always_comb begin
        en_d        = en_q;
        wren_d      = wren_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                rsp_valid_d = 1'b0;
                if (cmd_fire) begin
                    en_d   = 1'b1;
                    wren_d = !mig_icb_cmd_read_i;
                end
            end
            WR: begin
                if (en_q && app_rdy_i) en_d = 1'b0;
                if (wren_q && app_wdf_rdy_i) wren_d = 1'b0;
                if (wr_both_done) begin
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                end
            end
            RD_CMD: begin
                if (rd_timeout) begin
                    en_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    err_d       = 1'b1;
                end else if (app_rdy_i) begin
                    en_d = 1'b0;
                end
            end
            RD_WAIT: begin
                if (rd_timeout) begin
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    err_d       = 1'b1;
                end else if (app_rd_data_valid_i) begin
                    rsp_valid_d = 1'b1;
                    rdata_d     = app_rd_data_i[int'(lane_q)*32 +: 32];
                    err_d       = 1'b0;
                end
            end
            RSP: begin
                if (mig_icb_rsp_ready_i) rsp_valid_d = 1'b0;
            end
            default: begin
                en_d        = 1'b0;
                wren_d      = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Data mask is active-low per byte; only the addressed 32-bit lane is enabled.
    always_comb begin
        app_wdf_mask_o = '1;
        for (int l = 0; l < APP_DW / 32; l++) begin
            for (int b = 0; b < 4; b++) begin
                if (l == int'(lane_q)) app_wdf_mask_o[l*4+b] = ~wmask_q[b];
            end
        end
    end

    assign app_en_o       = en_q;
    assign app_cmd_o      = read_q ? APP_CMD_RD : APP_CMD_WR;
    assign app_addr_o     = {addr_q, 3'b000};
    assign app_wdf_wren_o = wren_q;
    assign app_wdf_end_o  = wren_q;
    assign app_wdf_data_o = {(APP_DW / 32){wdata_q}};

    assign mig_icb_rsp_valid_o   = rsp_valid_q;
    assign mig_icb_rsp_rdata_o   = rdata_q;
    assign mig_icb_rsp_err_o     = err_q;
    assign mig_icb_rsp_excl_ok_o = 1'b0;

    assign unused_inputs = &{1'b0, mig_icb_cmd_burst_i, mig_icb_cmd_beat_i, mig_icb_cmd_size_i,
                             mig_icb_cmd_lock_i, mig_icb_cmd_excl_i,
                             mig_icb_cmd_addr_i[`MYRISCV_ADDRDW-1:APP_AW+1],
                             mig_icb_cmd_addr_i[1:0], TIMEOUT_CYC[0]};

endmodule

// File: tb/tb_mig_icb_responder.sv
// Directed self-checking bench for mig_icb_responder.
// The read-timeout scenario is exercised only when MIG_ICB_RD_TIMEOUT_EN is defined.
`ifndef MYRISCV_ADDRDW
`define MYRISCV_ADDRDW 32
`endif

module tb_mig_icb_responder;

    localparam int APP_AW = 28;
    localparam int APP_DW = 128;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       cmdValid = 1'b0;
    logic                       cmdReady;
    logic [`MYRISCV_ADDRDW-1:0] cmdAddr = '0;
    logic                       cmdRead = 1'b0;
    logic [31:0]                cmdWdata = '0;
    logic [3:0]                 cmdWmask = '0;
    logic                       rspValid;
    logic                       rspReady = 1'b0;
    logic                       rspErr;
    logic                       rspExclOk;
    logic [31:0]                rspRdata;
    logic                       initCalib = 1'b1;
    logic                       appEn;
    logic [2:0]                 appCmd;
    logic [APP_AW-1:0]          appAddr;
    logic                       appRdy = 1'b1;
    logic                       appWdfWren;
    logic                       appWdfEnd;
    logic [APP_DW-1:0]          appWdfData;
    logic [APP_DW/8-1:0]        appWdfMask;
    logic                       appWdfRdy = 1'b1;
    logic [APP_DW-1:0]          appRdData = '0;
    logic                       appRdDataValid = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    mig_icb_responder #(
        .APP_AW(APP_AW),
        .APP_DW(APP_DW),
        .TIMEOUT_CYC(256)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .mig_icb_cmd_valid_i  (cmdValid),
        .mig_icb_cmd_ready_o  (cmdReady),
        .mig_icb_cmd_addr_i   (cmdAddr),
        .mig_icb_cmd_read_i   (cmdRead),
        .mig_icb_cmd_wdata_i  (cmdWdata),
        .mig_icb_cmd_wmask_i  (cmdWmask),
        .mig_icb_cmd_burst_i  (2'b00),
        .mig_icb_cmd_beat_i   (2'b00),
        .mig_icb_cmd_size_i   (2'b10),
        .mig_icb_cmd_lock_i   (1'b0),
        .mig_icb_cmd_excl_i   (1'b0),
        .mig_icb_rsp_valid_o  (rspValid),
        .mig_icb_rsp_ready_i  (rspReady),
        .mig_icb_rsp_err_o    (rspErr),
        .mig_icb_rsp_excl_ok_o(rspExclOk),
        .mig_icb_rsp_rdata_o  (rspRdata),
        .init_calib_complete_i(initCalib),
        .app_en_o             (appEn),
        .app_cmd_o            (appCmd),
        .app_addr_o           (appAddr),
        .app_rdy_i            (appRdy),
        .app_wdf_wren_o       (appWdfWren),
        .app_wdf_end_o        (appWdfEnd),
        .app_wdf_data_o       (appWdfData),
        .app_wdf_mask_o       (appWdfMask),
        .app_wdf_rdy_i        (appWdfRdy),
        .app_rd_data_i        (appRdData),
        .app_rd_data_valid_i  (appRdDataValid)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns one cycle after the handshake edge.
    task automatic applyStimulus(input logic rd, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [3:0] wm);
        int waitCnt = 0;
        cmdValid = 1'b1;
        cmdRead  = rd;
        cmdAddr  = addr;
        cmdWdata = wd;
        cmdWmask = wm;
        while (!cmdReady && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkOutput("cmd_accept", {127'd0, cmdReady}, 128'd1);
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic finishResponse(input string tag, input logic [31:0] expRdata, input logic expErr);
        int waitCnt = 0;
        while (!rspValid && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkOutput({tag, "_valid"}, {127'd0, rspValid}, 128'd1);
        checkOutput({tag, "_rdata"}, {96'd0, rspRdata}, {96'd0, expRdata});
        checkOutput({tag, "_err"}, {127'd0, rspErr}, {127'd0, expErr});
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checkOutput({tag, "_drop"}, {127'd0, rspValid}, 128'd0);
    endtask

    task automatic pulseRdValid(input logic [127:0] data);
        appRdData      = data;
        appRdDataValid = 1'b1;
        tick();
        appRdDataValid = 1'b0;
    endtask

    initial begin
        logic [31:0] heldRdata;

        #2;
        checkOutput("reset_app_en", {127'd0, appEn}, 128'd0);
        checkOutput("reset_wdf_mask", {112'd0, appWdfMask}, 128'hFFFF);
        checkOutput("reset_rsp_valid", {127'd0, rspValid}, 128'd0);
        checkOutput("reset_excl_ok", {127'd0, rspExclOk}, 128'd0);
        tick();
        rst = 1'b0;
        tick();

        // Write, both channels ready: response two cycles after the handshake.
        applyStimulus(1'b0, 32'h8000_0014, 32'hDEAD_BEEF, 4'hF);
        checkOutput("t1_app_en", {127'd0, appEn}, 128'd1);
        checkOutput("t1_wren", {127'd0, appWdfWren}, 128'd1);
        checkOutput("t1_wdf_end", {127'd0, appWdfEnd}, 128'd1);
        checkOutput("t1_app_cmd", {125'd0, appCmd}, 128'd0);
        checkOutput("t1_app_addr", {100'd0, appAddr}, 128'h8);
        checkOutput("t1_wdf_mask", {112'd0, appWdfMask}, 128'hFF0F);
        checkOutput("t1_wdf_data", appWdfData, {4{32'hDEAD_BEEF}});
        checkOutput("t1_cmd_ready_busy", {127'd0, cmdReady}, 128'd0);
        checkOutput("t1_rsp_early", {127'd0, rspValid}, 128'd0);
        tick();
        checkOutput("t1_rsp_latency", {127'd0, rspValid}, 128'd1);
        checkOutput("t1_app_en_done", {127'd0, appEn}, 128'd0);
        finishResponse("t1", 32'h0, 1'b0);
        checkOutput("t1_cmd_ready_back", {127'd0, cmdReady}, 128'd1);

        // Stray read data in IDLE must not produce a response.
        pulseRdValid(128'h1234);
        checkOutput("stray_idle", {127'd0, rspValid}, 128'd0);

        // Read from lane 2.
        applyStimulus(1'b1, 32'h8000_0018, 32'h0, 4'h0);
        checkOutput("t2_app_en", {127'd0, appEn}, 128'd1);
        checkOutput("t2_app_cmd", {125'd0, appCmd}, 128'd1);
        checkOutput("t2_app_addr", {100'd0, appAddr}, 128'h8);
        checkOutput("t2_wren", {127'd0, appWdfWren}, 128'd0);
        tick();
        checkOutput("t2_app_en_done", {127'd0, appEn}, 128'd0);
        pulseRdValid(128'h44444444_33333333_22222222_11111111);
        checkOutput("t2_rsp_latency", {127'd0, rspValid}, 128'd1);
        finishResponse("t2", 32'h3333_3333, 1'b0);

        // Write with app_rdy held low for five cycles; write data accepted at once.
        appRdy = 1'b0;
        applyStimulus(1'b0, 32'h8000_0024, 32'h1234_5678, 4'b0011);
        checkOutput("t3_wren_c1", {127'd0, appWdfWren}, 128'd1);
        checkOutput("t3_wdf_mask", {112'd0, appWdfMask}, 128'hFFCF);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t3_wren_off", {127'd0, appWdfWren}, 128'd0);
            checkOutput("t3_en_hold", {127'd0, appEn}, 128'd1);
            checkOutput("t3_addr_hold", {100'd0, appAddr}, 128'h10);
            checkOutput("t3_no_rsp", {127'd0, rspValid}, 128'd0);
        end
        appRdy = 1'b1;
        tick();
        checkOutput("t3_rsp_after_rdy", {127'd0, rspValid}, 128'd1);
        checkOutput("t3_en_done", {127'd0, appEn}, 128'd0);
        finishResponse("t3", 32'h0, 1'b0);

        // Read lane 0 with rsp_ready held low for three cycles.
        applyStimulus(1'b1, 32'h8000_0000, 32'h0, 4'h0);
        tick();
        pulseRdValid(128'h0_0000_0000_0000_0000_0000_CAFE_F00D);
        heldRdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t4_valid_hold", {127'd0, rspValid}, 128'd1);
            checkOutput("t4_rdata_hold", {96'd0, rspRdata}, {96'd0, heldRdata});
            checkOutput("t4_cmd_ready_low", {127'd0, cmdReady}, 128'd0);
            pulseRdValid(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
        end
        rspReady = 1'b1;
        checkOutput("t4_cmd_ready_hs", {127'd0, cmdReady}, 128'd0);
        tick();
        rspReady = 1'b0;
        checkOutput("t4_rsp_drop", {127'd0, rspValid}, 128'd0);
        checkOutput("t4_cmd_ready_after", {127'd0, cmdReady}, 128'd1);

        // Controller not calibrated: command is held off.
        initCalib = 1'b0;
        cmdValid  = 1'b1;
        cmdRead   = 1'b0;
        cmdAddr   = 32'h8000_0040;
        #1;
        checkOutput("t5_cmd_ready_gate", {127'd0, cmdReady}, 128'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t5_no_app_en", {127'd0, appEn}, 128'd0);
        end
        cmdValid  = 1'b0;
        initCalib = 1'b1;
        tick();

        // Reset while waiting for read data, then a late rd_data_valid.
        applyStimulus(1'b1, 32'h8000_000C, 32'h0, 4'h5);
        tick();
        rst = 1'b1;
        #2;
        checkOutput("t5_rst_app_en", {127'd0, appEn}, 128'd0);
        checkOutput("t5_rst_app_addr", {100'd0, appAddr}, 128'd0);
        checkOutput("t5_rst_wdf_mask", {112'd0, appWdfMask}, 128'hFFFF);
        checkOutput("t5_rst_rsp_valid", {127'd0, rspValid}, 128'd0);
        checkOutput("t5_rst_cmd", {125'd0, appCmd}, 128'd0);
        rst = 1'b0;
        tick();
        pulseRdValid(128'hAAAA_AAAA_0000_0000_0000_0000_0000_0000);
        checkOutput("t5_late_valid", {127'd0, rspValid}, 128'd0);
        checkOutput("t5_late_rdata", {96'd0, rspRdata}, 128'd0);
        checkOutput("t5_idle_ready", {127'd0, cmdReady}, 128'd1);

`ifdef MIG_ICB_RD_TIMEOUT_EN
        // No read data ever returns: watchdog answers 256 cycles after entering RD_CMD.
        applyStimulus(1'b1, 32'h8000_0008, 32'h0, 4'h0);
        for (int i = 0; i < 255; i++) tick();
        checkOutput("t6_not_yet", {127'd0, rspValid}, 128'd0);
        tick();
        checkOutput("t6_timeout_valid", {127'd0, rspValid}, 128'd1);
        finishResponse("t6", 32'h0, 1'b1);
        pulseRdValid(128'h5555_5555_5555_5555_5555_5555_5555_5555);
        checkOutput("t6_stray_after", {127'd0, rspValid}, 128'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule

// File: doc/mig_icb_responder.md
# mig_icb_responder

ICB responder that terminates the `mig_icb_*` port of the memory bus and drives a DDR controller user interface (app_* native port).
- Accepts one single-beat 32-bit ICB command at a time and issues one command to the controller.
- Packs write data and mask into the controller's 128-bit data word and extracts the addressed 32-bit lane from read data.
- Returns exactly one ICB response per command.
- Sits between the memory bus `mig_icb_*` outputs and the DDR controller IP.

## Interface
Parameters:
- APP_AW, 28, controller app_addr width.
- APP_DW, 128, controller data width; fixed 4 × `MYRISCV_DATADW`.
- TIMEOUT_CYC, 256, read-wait watchdog limit; used only with the timeout feature.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock; the controller UI clock.
- rst  in  1  asynchronous active-high reset.
- mig_icb_cmd_valid / _ready  in / out  1  command handshake.
- mig_icb_cmd_addr  in  `MYRISCV_ADDRDW  byte address.
- mig_icb_cmd_read  in  1  1 = read.
- mig_icb_cmd_wdata / _wmask  in  32 / 4  write data and byte enables.
- mig_icb_cmd_burst, _beat, _size, _lock, _excl  in  2, 2, 2, 1, 1  ignored.
- mig_icb_rsp_valid / _ready  out / in  1  response handshake.
- mig_icb_rsp_err  out  1  error flag.
- mig_icb_rsp_excl_ok  out  1  tied 0.
- mig_icb_rsp_rdata  out  32  read data.
- init_calib_complete  in  1  controller ready.
- app_en, app_cmd[2:0], app_addr[APP_AW-1:0]  out  command channel.
- app_rdy  in  1  command accepted.
- app_wdf_wren, app_wdf_end, app_wdf_data[APP_DW-1:0], app_wdf_mask[APP_DW/8-1:0]  out  write-data channel.
- app_wdf_rdy  in  1  write data accepted.
- app_rd_data[APP_DW-1:0], app_rd_data_valid  in  read return.

## Operation
States: IDLE, WR, RD_CMD, RD_WAIT, RSP.

**IDLE**
- cmd_ready = init_calib_complete.
- On a command handshake, register addr, read, wdata and wmask.
- Go to RD_CMD if read is 1; otherwise go to WR.

**Address and lane packing**
- app_addr = {addr[APP_AW:4], 3'b000}.
- Lane index: lane = addr[3:2].
- app_wdf_data = wdata replicated ×4.
- app_wdf_mask = all 1s, except byte positions lane*4+i, which take ~wmask[i].
- app_cmd = 3'b000 for write, 3'b001 for read.

**WR**
- app_en and app_wdf_wren assert together. app_wdf_end = app_wdf_wren.
- Each channel deasserts independently after its own handshake: app_en&app_rdy, app_wdf_wren&app_wdf_rdy.
- Once both have completed, go to RSP with err=0 and rdata=0.

**RD_CMD**
- app_en=1 until app_rdy, then go to RD_WAIT.

**RD_WAIT**
- On app_rd_data_valid, capture app_rd_data[lane*32 +: 32] into rdata, set err=0, go to RSP.

**RSP**
- rsp_valid=1; rdata and err held stable.
- On rsp_ready, go to IDLE.

**Other rules**
- app_rd_data_valid outside RD_WAIT is ignored.
- Only one command is outstanding at any time.
- cmd_ready is low in every state other than IDLE.

**Reset**
- Reset (any time, including mid-transaction) forces IDLE.
- All outputs reset to 0 except app_wdf_mask, which resets to all 1s.

## Timing
- Command accepted at cycle T; app_en (and app_wdf_wren for writes) is high from T+1. Outputs are registered.
- app_addr, app_cmd and the wdf data/mask are stable while their enable is high.
- Write response: rsp_valid rises the cycle after the later of the two channel handshakes.
- Read response: rsp_valid rises the cycle after app_rd_data_valid.
- The next cmd_ready rises the cycle after the response handshake.
- Minimum write latency, cmd handshake to rsp_valid: 2 cycles.
- If init_calib_complete falls while in IDLE, cmd_ready drops the same cycle (combinational gate). A transaction already in flight completes.

## Configuration
Macro: MIG_ICB_RD_TIMEOUT_EN.

Defined:
- A counter clears on entry to RD_CMD and increments each cycle spent in RD_CMD or RD_WAIT.
- When it reaches TIMEOUT_CYC, go to RSP with err=1 and rdata=0, and drop app_en.
- A later stray app_rd_data_valid is ignored.

Undefined:
- No counter; the block waits indefinitely.
- err is always 0.

## Structure
- Package mig_icb_pkg holds the state enum, APP_CMD_WR/APP_CMD_RD constants, and the lane-index width.
- One sub-module, mig_icb_rd_timeout, holds the counter and an expiry pulse. It is instantiated only under MIG_ICB_RD_TIMEOUT_EN.
- The FSM and lane packing stay in the top module.

## Test plan
1. Write at 0x8000_0014, wdata 0xDEADBEEF, wmask 4'hF, app_rdy=app_wdf_rdy=1 → app_cmd 000; app_wdf_mask 16'hFF0F; data word 0xDEADBEEF×4; rsp err 0 two cycles after the handshake.
2. Read at 0x8000_0018 returning 128'h44444444_33333333_22222222_11111111 → rsp_rdata 0x33333333, err 0.
3. Write with app_rdy low for 5 cycles and app_wdf_rdy high → wren drops after 1 cycle; app_en and app_addr stay stable for 5 cycles; response follows app_rdy.
4. rsp_ready held low for 3 cycles → rsp_valid and rdata stable; cmd_ready stays 0 until the cycle after the handshake.
5. init_calib_complete=0 with cmd_valid=1 → cmd_ready 0 and no app_en. Separately, rst pulsed in RD_WAIT → IDLE, all outputs at reset values, and a late rd_data_valid is ignored.
6. MIG_ICB_RD_TIMEOUT_EN with TIMEOUT_CYC=256 and no rd_data_valid → rsp err=1, rdata 0, 256 cycles after entering RD_CMD.
